ex_hazard_ctrl: RTL
===================

// Module: ex_hazard_ctrl
// PURPOSE
// Control-hazard and load-use sequencer for the 5-stage pipeline. Watches ID-stage
// operands/branch and EX-stage results (ex_branch, ex_zero, ex_pc, ex_destR,
// ex_m2reg). Drives PC select, IF/ID freeze and flush, and ID/EX bubble insertion.
// Keeps stall/flush event counters for the debug display.
// PARAMETERS
// BR_POLICY  0   0 = predict-not-taken + flush; 1 = stall fetch on every decoded branch
// BR_STALL   2   fetch-freeze cycles per branch when BR_POLICY=1 (legal 1..3)
// CNT_W      16  width of performance counters
// PORTS
// clk          in   1      pipeline clock, all state on rising edge
// rst          in   1      asynchronous, active-high reset
// id_rs        in   5      rs field of instruction in ID
// id_rt        in   5      rt field of instruction in ID
// id_use_rs    in   1      ID instruction reads rs
// id_use_rt    in   1      ID instruction reads rt
// id_branch    in   1      ID instruction is a branch (beq)
// ex_branch    in   1      EX instruction is a branch
// ex_zero      in   1      EX compare result (1 = operands equal)
// ex_pc        in   32     EX branch target (pc4 + offset)
// ex_wreg      in   1      EX instruction writes a register
// ex_m2reg     in   1      EX instruction is a load
// ex_destR     in   5      EX destination register
// pc_sel       out  1      1 = next PC is pc_target
// pc_target    out  32     redirect address (= ex_pc when pc_sel)
// pc_hold      out  1      PC register keeps its value
// ifid_hold    out  1      IF/ID register keeps its value
// ifid_flush   out  1      IF/ID loads a NOP
// idex_bubble  out  1      ID/EX loads all-zero controls (wreg=m2reg=wmem=branch=0)
// cnt_flush    out  CNT_W  taken-branch redirects since reset
// cnt_stall    out  CNT_W  cycles with pc_hold=1 since reset
// BEHAVIOUR
// - Control outputs are Mealy: combinational from state + inputs, same-cycle effect.
// - Forced to 0 while rst=1. pc_target is 0 when pc_sel=0.
// - taken  = ex_branch & ex_zero.
// - lduse  = ex_m2reg & ex_wreg & (ex_destR!=0)
//            & ((id_use_rs & id_rs==ex_destR) | (id_use_rt & id_rt==ex_destR)).
// - FSM states: RUN, LDSTALL, BRWAIT. Reset -> RUN. Counters reset to 0.
// - Priority each cycle: taken > lduse > branch-wait.
// - taken (any state):
//   - pc_sel=1, pc_target=ex_pc, ifid_flush=1, idex_bubble=1, pc_hold=ifid_hold=0;
//   - cnt_flush++; next state RUN, wait counter cleared.
// - RUN, lduse & !taken:
//   - pc_hold=ifid_hold=1, idex_bubble=1; next LDSTALL.
// - LDSTALL:
//   - no outputs asserted; next RUN (load reached MEM, forwarding path covers it).
//   - A fresh lduse here re-stalls (new pair).
// - RUN, BR_POLICY=1, id_branch & !lduse & !taken:
//   - pc_hold=ifid_hold=1 on entry and for BR_STALL-1 further cycles;
//   - ifid_flush=1 on the last stall cycle; wait counter loads BR_STALL-1; next BRWAIT.
// - BRWAIT:
//   - counter>0: hold, decrement. counter==0 or taken: return RUN.
//   - idex_bubble=0 (branch itself must advance).
// - BR_POLICY=0: id_branch ignored; BRWAIT unreachable.
// - Counters:
//   - saturate at all-ones, no wrap;
//   - cnt_stall counts every cycle pc_hold=1 (lduse and branch-wait).
// - Reset mid-stall/mid-BRWAIT: immediate RUN, all outputs 0, counters 0.
// TESTING
// - lw $1,0($0); add $2,$1,$3 -> one cycle pc_hold=ifid_hold=idex_bubble=1, then RUN; cnt_stall=1.
// - beq taken, ex_pc=0x0000_0040 -> pc_sel=1, pc_target=0x40, ifid_flush=idex_bubble=1 one cycle; cnt_flush=1.
// - lduse and taken in same cycle -> only redirect/flush; pc_hold=0; state RUN.
// - BR_POLICY=1, BR_STALL=2, not-taken beq -> pc_hold 2 cycles, ifid_flush on 2nd; cnt_stall=2.
// - lw to $0 followed by use of $0 -> no stall.
// - rst pulsed during BRWAIT -> outputs 0 asynchronously, counters 0; next beq behaves as from reset.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// Control-hazard and load-use sequencer for the 5-stage pipeline.
// Mealy control outputs from a three-state FSM, plus saturating stall/flush counters.
module ex_hazard_ctrl #(
    parameter int BR_POLICY = 0,
    parameter int BR_STALL  = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [31:0]      ex_pc,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_destR,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_stall
);

    generate
        if (BR_STALL < 1 || BR_STALL > 3) begin : g_bad_stall
            $error("BR_STALL must be in 1..3");
        end
    endgenerate

    typedef enum logic [1:0] {RUN, LDSTALL, BRWAIT} state_t;

    typedef struct packed {
        logic pc_sel;
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_bubble;
    } ctl_t;

    localparam logic [1:0] WAIT_LOAD = 2'(BR_STALL - 1);

    state_t     state, state_nxt;
    logic [1:0] wait_cnt, wait_nxt;
    ctl_t       ctl;
    logic       taken, lduse, rs_hit, rt_hit;

    assign taken  = ex_branch & ex_zero;
    assign rs_hit = id_use_rs & (id_rs == ex_destR);
    assign rt_hit = id_use_rt & (id_rt == ex_destR);
    // A load into $0 never produces a real dependency.
    assign lduse  = ex_m2reg & ex_wreg & (ex_destR != 5'd0) & (rs_hit | rt_hit);

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (taken) begin
            ctl.pc_sel      = 1'b1;
            ctl.ifid_flush  = 1'b1;
            ctl.idex_bubble = 1'b1;
            state_nxt       = RUN;
            wait_nxt        = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (lduse) begin
                        ctl.pc_hold     = 1'b1;
                        ctl.ifid_hold   = 1'b1;
                        ctl.idex_bubble = 1'b1;
                        state_nxt       = LDSTALL;
                    end else if (BR_POLICY != 0 && id_branch) begin
                        ctl.pc_hold    = 1'b1;
                        ctl.ifid_hold  = 1'b1;
                        ctl.ifid_flush = (BR_STALL == 1);
                        wait_nxt       = WAIT_LOAD;
                        state_nxt      = BRWAIT;
                    end
                end
                LDSTALL: begin
                    // Load is now in MEM; only a new dependent pair stalls again.
                    if (lduse) begin
                        ctl.pc_hold     = 1'b1;
                        ctl.ifid_hold   = 1'b1;
                        ctl.idex_bubble = 1'b1;
                        state_nxt       = LDSTALL;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                BRWAIT: begin
                    if (wait_cnt != 2'd0) begin
                        ctl.pc_hold    = 1'b1;
                        ctl.ifid_hold  = 1'b1;
                        ctl.ifid_flush = (wait_cnt == 2'd1);
                        wait_nxt       = wait_cnt - 2'd1;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    wait_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign pc_sel      = ctl.pc_sel      & ~rst;
    assign pc_hold     = ctl.pc_hold     & ~rst;
    assign ifid_hold   = ctl.ifid_hold   & ~rst;
    assign ifid_flush  = ctl.ifid_flush  & ~rst;
    assign idex_bubble = ctl.idex_bubble & ~rst;
    assign pc_target   = pc_sel ? ex_pc : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_flush <= '0;
            cnt_stall <= '0;
        end else begin
            if (pc_sel && cnt_flush != '1)
                cnt_flush <= cnt_flush + 1'b1;
            if (pc_hold && cnt_stall != '1)
                cnt_stall <= cnt_stall + 1'b1;
        end
    end

endmodule
